hbm_rw_scheduler: RTL and testbench

HBM_RW_SCHEDULER -- requirements
Module: hbm_rw_scheduler

---
 rtl/hbm_pd_pkg.sv | 15 +
 rtl/delta_counter.sv | 24 ++
 rtl/hbm_rw_scheduler.sv | 142 ++++++++++++++
 tb/tb_hbm_rw_scheduler.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hbm_pd_pkg.sv
// rtl/hbm_pd_pkg.sv - shared state encoding and default limits for the HBM read/write scheduler
package hbm_pd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_e;

  localparam int unsigned HbmMaxBatch   = 8;
  localparam int unsigned HbmTurnCycles = 4;
  localparam int unsigned HbmMaxTxns    = 16;

endpackage

// File: rtl/delta_counter.sv
// rtl/delta_counter.sv - up/down counter stepping by delta_i when enabled
module delta_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (clear_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= down_i ? (q_o - delta_i) : (q_o + delta_i);
    end
  end

endmodule

// File: rtl/hbm_rw_scheduler.sv
// rtl/hbm_rw_scheduler.sv - batches AR/AW grants toward one HBM channel with turnaround bubbles
module hbm_rw_scheduler
  import hbm_pd_pkg::*;
#(
  parameter int unsigned MaxBatch   = HbmMaxBatch,
  parameter int unsigned TurnCycles = HbmTurnCycles,
  parameter int unsigned MaxRdTxns  = HbmMaxTxns,
  parameter int unsigned MaxWrTxns  = HbmMaxTxns
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ar_valid_i,
  output logic       ar_ready_o,
  input  logic       aw_valid_i,
  output logic       aw_ready_o,
  output logic       mem_ar_valid_o,
  input  logic       mem_ar_ready_i,
  output logic       mem_aw_valid_o,
  input  logic       mem_aw_ready_i,
  input  logic       r_last_done_i,
  input  logic       b_done_i,
  output logic [1:0] state_o,
  output logic       busy_o
);

  localparam int unsigned RdW    = $clog2(MaxRdTxns + 1);
  localparam int unsigned WrW    = $clog2(MaxWrTxns + 1);
  localparam int unsigned BatchW = $clog2(MaxBatch + 1);
  localparam logic [RdW-1:0]    RdMax     = RdW'(MaxRdTxns);
  localparam logic [WrW-1:0]    WrMax     = WrW'(MaxWrTxns);
  localparam logic [BatchW-1:0] BatchLast = BatchW'(MaxBatch - 1);
  localparam logic [3:0]        TurnLoad  = 4'(TurnCycles - 1);
  localparam logic              DirRead   = 1'b0;
  localparam logic              DirWrite  = 1'b1;

  state_e            state;
  logic              last_dir;
  logic [BatchW-1:0] batch_cnt;
  logic [3:0]        turn_cnt;
  logic [RdW-1:0]    rd_cnt;
  logic [WrW-1:0]    wr_cnt;

  logic rd_gate, wr_gate, ar_hs, aw_hs, hs, stall, batch_full, same_req, opp_req;
  logic rd_en, wr_en;

  assign rd_gate        = (state == READ)  && (rd_cnt < RdMax);
  assign wr_gate        = (state == WRITE) && (wr_cnt < WrMax);
  assign mem_ar_valid_o = ar_valid_i & rd_gate;
  assign ar_ready_o     = mem_ar_ready_i & rd_gate;
  assign mem_aw_valid_o = aw_valid_i & wr_gate;
  assign aw_ready_o     = mem_aw_ready_i & wr_gate;

  assign ar_hs      = mem_ar_valid_o & mem_ar_ready_i;
  assign aw_hs      = mem_aw_valid_o & mem_aw_ready_i;
  assign hs         = ar_hs | aw_hs;
  // A presented-but-unaccepted request pins the current direction.
  assign stall      = (mem_ar_valid_o & ~mem_ar_ready_i) | (mem_aw_valid_o & ~mem_aw_ready_i);
  assign batch_full = hs && (batch_cnt == BatchLast);
  assign same_req   = (state == WRITE) ? aw_valid_i : ar_valid_i;
  assign opp_req    = (state == WRITE) ? ar_valid_i : aw_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_dir  <= DirRead;
      batch_cnt <= '0;
      turn_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          batch_cnt <= '0;
          if (ar_valid_i && aw_valid_i) state <= (last_dir == DirRead) ? WRITE : READ;
          else if (ar_valid_i)          state <= READ;
          else if (aw_valid_i)          state <= WRITE;
        end
        READ, WRITE: begin
          if (!stall) begin
            if (opp_req && (batch_full || !same_req)) begin
              state     <= TURN;
              last_dir  <= (state == WRITE) ? DirWrite : DirRead;
              batch_cnt <= '0;
              turn_cnt  <= TurnLoad;
            end else if (!same_req && !opp_req) begin
              state     <= IDLE;
              last_dir  <= (state == WRITE) ? DirWrite : DirRead;
              batch_cnt <= '0;
            end else if (batch_full) begin
              batch_cnt <= '0;
            end else if (hs) begin
              batch_cnt <= batch_cnt + 1'b1;
            end
          end
        end
        TURN: begin
          // The target is always the direction opposite the one just left.
          if (turn_cnt == 4'd0) begin
            state     <= (last_dir == DirWrite) ? READ : WRITE;
            batch_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Matched inc/dec cancels; a response with nothing outstanding is dropped.
  assign rd_en = (ar_hs ^ r_last_done_i) & ~(r_last_done_i & (rd_cnt == '0));
  assign wr_en = (aw_hs ^ b_done_i) & ~(b_done_i & (wr_cnt == '0));

  delta_counter #(.WIDTH(RdW)) u_rd_cnt (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .clear_i (1'b0),
    .en_i    (rd_en),
    .down_i  (r_last_done_i),
    .delta_i (RdW'(1)),
    .q_o     (rd_cnt)
  );

  delta_counter #(.WIDTH(WrW)) u_wr_cnt (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .clear_i (1'b0),
    .en_i    (wr_en),
    .down_i  (b_done_i),
    .delta_i (WrW'(1)),
    .q_o     (wr_cnt)
  );

  assign state_o = state;
  assign busy_o  = (rd_cnt != '0) | (wr_cnt != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(r_last_done_i && !ar_hs && (rd_cnt == '0))) else $warning("rd_cnt underflow on r_last_done_i");
      assert (!(b_done_i && !aw_hs && (wr_cnt == '0))) else $warning("wr_cnt underflow on b_done_i");
    end
  end

endmodule

// File: tb/tb_hbm_rw_scheduler.sv
// tb/tb_hbm_rw_scheduler.sv - vector table plus directed sequences for hbm_rw_scheduler
module tb_hbm_rw_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ar_valid, aw_valid, mem_ar_ready, mem_aw_ready, r_last_done, b_done;
  logic       ar_ready, aw_ready, mem_ar_valid, mem_aw_valid, busy;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hbm_rw_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ar_valid_i     (ar_valid),
    .ar_ready_o     (ar_ready),
    .aw_valid_i     (aw_valid),
    .aw_ready_o     (aw_ready),
    .mem_ar_valid_o (mem_ar_valid),
    .mem_ar_ready_i (mem_ar_ready),
    .mem_aw_valid_o (mem_aw_valid),
    .mem_aw_ready_i (mem_aw_ready),
    .r_last_done_i  (r_last_done),
    .b_done_i       (b_done),
    .state_o        (state),
    .busy_o         (busy)
  );

  typedef struct {
    logic ar_v, aw_v, ar_rdy, aw_rdy, rd_done, wr_done;
    int   st;
    logic ar_ready, mem_ar_v, aw_ready, mem_aw_v, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic arv, awv, int st, logic busy_e);
    vec_t v;
    v.ar_v = arv; v.aw_v = awv; v.ar_rdy = 1'b1; v.aw_rdy = 1'b1;
    v.rd_done = 1'b0; v.wr_done = 1'b0; v.st = st;
    v.ar_ready = (st == 1); v.mem_ar_v = (st == 1) && arv;
    v.aw_ready = (st == 2); v.mem_aw_v = (st == 2) && awv;
    v.busy = busy_e;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic arv, awv, arr, awr, rd, bd);
    ar_valid = arv; aw_valid = awv; mem_ar_ready = arr; mem_aw_ready = awr;
    r_last_done = rd; b_done = bd;
  endtask

  task automatic check_all(input string tag, input int st, input logic arr, marv, awr, mawv, bsy);
    chk({tag, " state"}, int'(state), st);
    chk({tag, " ar_ready"}, int'(ar_ready), int'(arr));
    chk({tag, " mem_ar_valid"}, int'(mem_ar_valid), int'(marv));
    chk({tag, " aw_ready"}, int'(aw_ready), int'(awr));
    chk({tag, " mem_aw_valid"}, int'(mem_aw_valid), int'(mawv));
    chk({tag, " busy"}, int'(busy), int'(bsy));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int st_e;
    drive(1, 1, 1, 1, 0, 0);
    @(negedge clk);
    #1 check_all("reset", 0, 0, 0, 0, 0, 0);
    do_reset();

    // Mixed traffic: one IDLE cycle, 8 writes, 4 turn, 8 reads, 4 turn, writes again.
    for (int c = 0; c <= 26; c++) begin
      st_e = (c == 0) ? 0 : (c <= 8) ? 2 : (c <= 12) ? 3 : (c <= 20) ? 1 : (c <= 24) ? 3 : 2;
      add(1, 1, st_e, c >= 2);
    end
    add(0, 0, 2, 1);
    add(0, 0, 0, 1);
    add(1, 1, 0, 1);
    add(1, 1, 1, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ar_v, vecs[i].aw_v, vecs[i].ar_rdy, vecs[i].aw_rdy, vecs[i].rd_done, vecs[i].wr_done);
      #1 check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ar_ready, vecs[i].mem_ar_v,
                   vecs[i].aw_ready, vecs[i].mem_aw_v, vecs[i].busy);
      @(negedge clk);
    end

    // Outstanding limit and simultaneous inc/dec on rd_cnt.
    do_reset();
    drive(1, 0, 1, 1, 0, 0);
    #1 check_all("lim idle", 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      #1 check_all($sformatf("lim hs%0d", c), 1, 1, 1, 0, 0, c >= 2);
    end
    @(negedge clk);
    #1 check_all("lim stall", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 1, 1, 1, 0);
    #1 check_all("lim done cyc", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1 check_all("lim 17th", 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    drive(1, 0, 1, 1, 0, 0);
    #1 check_all("lim after simul", 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    #1 check_all("lim full again", 1, 0, 0, 0, 0, 1);

    // Valid held through backpressure; yield only after the 8th read handshake.
    do_reset();
    drive(1, 0, 1, 1, 0, 0);
    for (int c = 0; c <= 18; c++) begin
      if (c == 8)  drive(1, 1, 0, 1, 0, 0);
      if (c == 13) drive(1, 1, 1, 1, 0, 0);
      #1;
      if (c == 0)       check_all("stab idle", 0, 0, 0, 0, 0, 0);
      else if (c <= 7)  check_all($sformatf("stab hs%0d", c), 1, 1, 1, 0, 0, c >= 2);
      else if (c <= 12) check_all($sformatf("stab hold%0d", c), 1, 0, 1, 0, 0, 1);
      else if (c == 13) check_all("stab 8th", 1, 1, 1, 0, 0, 1);
      else if (c <= 17) check_all($sformatf("stab turn%0d", c), 3, 0, 0, 0, 0, 1);
      else              check_all("stab write", 2, 0, 0, 1, 1, 1);
      @(negedge clk);
    end

    // Response underflow keeps wr_cnt at zero.
    do_reset();
    drive(0, 0, 1, 1, 0, 1);
    #1 check_all("uflow pulse", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 1, 0, 0);
    #1 check_all("uflow after", 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Asynchronous reset in WRITE with five writes outstanding.
    do_reset();
    drive(0, 1, 1, 1, 0, 0);
    repeat (6) @(negedge clk);
    #1 check_all("mrst before", 2, 0, 0, 1, 1, 1);
    #1 rst = 1'b1;
    #1 check_all("mrst during", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
